// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: groups the receiver's configuration, serial input and read-side FIFO port.
// Latency: none, this is a bundle of wires.
// Backpressure: the read side is valid/ready (rd_valid/rd_ready); the serial side cannot be stalled.
//
// Ports (as seen by the receiver, slave modport):
//   en, clk_div, data_size, parity_en, parity_mode, stop2 : configuration inputs
//   rx                                                  : serial line, idle high
//   rd_data, rd_err, rd_valid, rd_ready, count          : head-of-FIFO read port
//   overrun, ovr_clr                                    : sticky drop flag and its clear
//   busy                                                : receiver is mid-frame
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
);
    logic                          en;
    logic [DIV_WIDTH-1:0]          clk_div;
    logic [1:0]                    data_size;
    logic                          parity_en;
    logic [1:0]                    parity_mode;
    logic                          stop2;
    logic                          rx;
    logic [7:0]                    rd_data;
    logic [1:0]                    rd_err;
    logic                          rd_valid;
    logic                          rd_ready;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          overrun;
    logic                          ovr_clr;
    logic                          busy;

    modport master (
        output en, clk_div, data_size, parity_en, parity_mode, stop2, rx, rd_ready, ovr_clr,
        input  rd_data, rd_err, rd_valid, count, overrun, busy
    );

    modport slave (
        input  en, clk_div, data_size, parity_en, parity_mode, stop2, rx, rd_ready, ovr_clr,
        output rd_data, rd_err, rd_valid, count, overrun, busy
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a FIFO of {frame err, parity err, data} entries.
// Latency: entry appears on rd_* the cycle after the last stop-bit sample (+2 clk with UART_RX_SYNC_EN).
// Backpressure: none toward the line; a frame arriving on a full FIFO with no pop is dropped and sets overrun.
//
// Ports: i_clk (rising edge), i_rst (synchronous, active high), bus (uart_rx_fifo_if.slave).
// Optional feature macro: UART_RX_SYNC_EN adds a 2-flop synchronizer (reset to 1) on rx.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_rx_fifo_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TCNT_W = $clog2(OVERSAMPLE);

    // Start bit is checked 7 ticks after the detecting tick (tick index OVERSAMPLE/2-1 counting
    // the detecting tick as 0); the counter is compared before its increment, hence the -2.
    localparam logic [TCNT_W-1:0] T_START = TCNT_W'(OVERSAMPLE / 2 - 2);
    localparam logic [TCNT_W-1:0] T_BIT   = TCNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- oversample tick divider ----------------
    logic [DIV_WIDTH-1:0] r_div;
    logic                 w_tick;

    assign w_tick = bus.en && (r_div == bus.clk_div);

    always_ff @(posedge i_clk) begin
        if (i_rst || !bus.en || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_WIDTH'(1);
        end
    end

    // ---------------- serial input ----------------
    logic w_rx;
`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], bus.rx};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = bus.rx;
`endif

    // ---------------- frame FSM ----------------
    state_t              r_state;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [2:0]          r_bitcnt;
    logic                r_stopcnt;
    logic [7:0]          r_data;
    logic                r_perr;
    logic                r_ferr;
    logic [1:0]          r_dsize;
    logic                r_par_en;
    logic [1:0]          r_par_mode;
    logic                r_stop2;

    logic                w_last_bit;
    logic                w_mid;
    logic                w_exp_par;
    logic                w_push;
    logic [9:0]          w_push_dat;

    assign w_last_bit = (r_bitcnt == (3'd4 + {1'b0, r_dsize}));
    assign w_mid      = w_tick && (r_tcnt == T_BIT);

    // Unused upper data bits are held at 0, so reducing over all 8 bits is safe.
    always_comb begin
        w_exp_par = 1'b0;
        case (r_par_mode)
            2'b11:   w_exp_par = ~^r_data;
            2'b10:   w_exp_par = ^r_data;
            2'b01:   w_exp_par = 1'b1;
            default: w_exp_par = 1'b0;
        endcase
    end

    // The final stop sample folds straight into the pushed frame-error flag.
    assign w_push     = (r_state == S_STOP) && w_mid && (r_stopcnt == r_stop2);
    assign w_push_dat = {r_ferr | ~w_rx, r_perr, r_data};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tcnt     <= '0;
            r_bitcnt   <= '0;
            r_stopcnt  <= 1'b0;
            r_data     <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_dsize    <= '0;
            r_par_en   <= 1'b0;
            r_par_mode <= '0;
            r_stop2    <= 1'b0;
        end else if (!bus.en) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
        end else if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx) begin
                        r_state <= S_START;
                        r_tcnt  <= '0;
                    end
                end
                S_START: begin
                    if (r_tcnt == T_START) begin
                        if (w_rx) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state    <= S_DATA;
                            r_tcnt     <= '0;
                            r_bitcnt   <= '0;
                            r_data     <= '0;
                            r_perr     <= 1'b0;
                            r_ferr     <= 1'b0;
                            r_dsize    <= bus.data_size;
                            r_par_en   <= bus.parity_en;
                            r_par_mode <= bus.parity_mode;
                            r_stop2    <= bus.stop2;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_tcnt == T_BIT) begin
                        r_tcnt           <= '0;
                        r_data[r_bitcnt] <= w_rx;
                        r_bitcnt         <= r_bitcnt + 3'd1;
                        if (w_last_bit) begin
                            r_stopcnt <= 1'b0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (r_tcnt == T_BIT) begin
                        r_tcnt  <= '0;
                        r_perr  <= (w_rx != w_exp_par);
                        r_state <= S_STOP;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_tcnt == T_BIT) begin
                        r_tcnt <= '0;
                        if (!w_rx) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_stopcnt == r_stop2) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_stopcnt <= 1'b1;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- receive FIFO ----------------
    logic [9:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovr;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic [9:0]       w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop   = bus.rd_ready && !w_empty;
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A new drop wins over a coincident clear.
            if (w_push && !w_wr) begin
                r_ovr <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign bus.rd_valid = !w_empty;
    assign bus.rd_data  = w_empty ? 8'h00 : w_head[7:0];
    assign bus.rd_err   = w_empty ? 2'b00 : w_head[9:8];
    assign bus.count    = r_count;
    assign bus.overrun  = r_ovr;
    assign bus.busy     = (r_state != S_IDLE);
endmodule
